// File: rtl/ariane_pkg.sv
// Core-level types shared by the branch unit, the BHT and the update queue between them.
package ariane_pkg;

    localparam int unsigned VLEN                = 64;
    localparam int unsigned BHT_UPD_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

// File: rtl/bht_update_compact.sv
// Packs the valid update lanes in port order into the first free slots, up to avail_i;
// the rest are reported as dropped.
module bht_update_compact
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned AW       = 3,
    parameter int unsigned NW       = $clog2(NR_PORTS + 1)
) (
    input  bht_update_t       update_i  [NR_PORTS],
    input  logic [AW-1:0]     avail_i,
    output bht_update_t       entries_o [NR_PORTS],
    output logic [NW-1:0]     n_acc_o,
    output logic [NW-1:0]     n_drop_o
);

    localparam int unsigned IW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    always_comb begin
        int w_acc;
        int w_drp;
        w_acc = 0;
        w_drp = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            entries_o[i] = '0;
        end
        for (int i = 0; i < NR_PORTS; i++) begin
            if (update_i[i].valid) begin
                if (w_acc < int'(avail_i)) begin
                    entries_o[IW'(w_acc)] = update_i[i];
                    w_acc = w_acc + 1;
                end else begin
                    w_drp = w_drp + 1;
                end
            end
        end
        n_acc_o  = NW'(w_acc);
        n_drop_o = NW'(w_drp);
    end

endmodule

// File: rtl/bht_update_queue.sv
// Order-preserving queue between the multi-port branch resolve path and the single BHT write port.
// Overflowing updates are dropped and counted in a saturating counter.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = BHT_UPD_QUEUE_DEPTH,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               debug_mode_i,
    input  bht_update_t        update_i [NR_PORTS],
    output bht_update_t        update_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [CNT_W-1:0]   drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = $clog2(NR_PORTS + 1);

    bht_update_t        r_mem [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_empty;
    logic               w_pop;
    logic [CW-1:0]      w_avail;
    bht_update_t        w_entries [NR_PORTS];
    logic [NW-1:0]      w_n_acc;
    logic [NW-1:0]      w_n_drop;
    logic [CNT_W:0]     w_drop_sum;

    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && !debug_mode_i;
    assign w_avail    = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_n_drop);

    bht_update_compact #(
        .NR_PORTS (NR_PORTS),
        .AW       (CW),
        .NW       (NW)
    ) u_compact (
        .update_i  (update_i),
        .avail_i   (w_avail),
        .entries_o (w_entries),
        .n_acc_o   (w_n_acc),
        .n_drop_o  (w_n_drop)
    );

    // Flush wins over everything but reset; debug freezes the queue and ignores inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (!debug_mode_i) begin
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_wr_ptr <= r_wr_ptr + PW'(w_n_acc);
            r_count  <= r_count - CW'(w_pop) + CW'(w_n_acc);
            for (int j = 0; j < NR_PORTS; j++) begin
                if (j < int'(w_n_acc)) begin
                    r_mem[r_wr_ptr + PW'(j)] <= w_entries[j];
                end
            end
            if (w_n_drop != '0) begin
                r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
            end
        end
    end

    assign update_o.valid = w_pop;
    assign update_o.pc    = r_mem[r_rd_ptr].pc;
    assign update_o.taken = r_mem[r_rd_ptr].taken;
    assign empty_o        = w_empty;
    assign full_o         = (r_count == CW'(DEPTH));
    assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: directed scenarios plus random traffic against a queue-based model.
module tb_bht_update_queue;
    import ariane_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        debug_mode_i;
    bht_update_t update_i [2];
    bht_update_t update_o, update_o_s;
    logic        empty_o, full_o, empty_s, full_s;
    logic [15:0] drop_cnt_o;
    logic [1:0]  drop_s;

    always #5 clk_i = ~clk_i;

    bht_update_queue #(.NR_PORTS(2), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .update_i(update_i), .update_o(update_o), .empty_o(empty_o), .full_o(full_o),
        .drop_cnt_o(drop_cnt_o)
    );

    bht_update_queue #(.NR_PORTS(2), .DEPTH(4), .CNT_W(2)) u_dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .update_i(update_i), .update_o(update_o_s), .empty_o(empty_s), .full_o(full_s),
        .drop_cnt_o(drop_s)
    );

    typedef struct {
        logic [VLEN-1:0] pc;
        logic            taken;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_drops;
    int          checks   = 0;
    int          failures = 0;

    task automatic drive(input logic fl, input logic dbg,
                         input logic v0, input logic [VLEN-1:0] p0, input logic t0,
                         input logic v1, input logic [VLEN-1:0] p1, input logic t1);
        flush_i        = fl;
        debug_mode_i   = dbg;
        update_i[0]    = '{valid: v0, pc: p0, taken: t0};
        update_i[1]    = '{valid: v1, pc: p1, taken: t1};
    endtask

    // Invalid lanes carry random junk so ignored lanes are exercised.
    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
    endtask

    task automatic check_outputs(input string tag);
        logic        exp_v;
        int unsigned exp_d16, exp_d2;
        exp_v   = (mq.size() > 0) && !debug_mode_i;
        exp_d16 = (m_drops > 65535) ? 65535 : m_drops;
        exp_d2  = (m_drops > 3) ? 3 : m_drops;
        checks++;
        if (update_o.valid !== exp_v) begin
            failures++;
            $display("FAIL %s valid: got %b expected %b", tag, update_o.valid, exp_v);
        end
        if (exp_v) begin
            checks++;
            if (update_o.pc !== mq[0].pc || update_o.taken !== mq[0].taken) begin
                failures++;
                $display("FAIL %s head: got pc=%h t=%b expected pc=%h t=%b",
                         tag, update_o.pc, update_o.taken, mq[0].pc, mq[0].taken);
            end
        end
        checks++;
        if (empty_o !== (mq.size() == 0)) begin
            failures++;
            $display("FAIL %s empty: got %b expected %b", tag, empty_o, mq.size() == 0);
        end
        checks++;
        if (full_o !== (mq.size() == 4)) begin
            failures++;
            $display("FAIL %s full: got %b expected %b", tag, full_o, mq.size() == 4);
        end
        checks++;
        if (drop_cnt_o !== 16'(exp_d16)) begin
            failures++;
            $display("FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt_o, exp_d16);
        end
        checks++;
        if (drop_s !== 2'(exp_d2)) begin
            failures++;
            $display("FAIL %s drop_cnt_sat: got %0d expected %0d", tag, drop_s, exp_d2);
        end
    endtask

    task automatic model_advance();
        if (flush_i) begin
            mq.delete();
        end else if (!debug_mode_i) begin
            if (mq.size() > 0) void'(mq.pop_front());
            for (int p = 0; p < 2; p++) begin
                if (update_i[p].valid) begin
                    if (mq.size() < 4) mq.push_back('{pc: update_i[p].pc, taken: update_i[p].taken});
                    else m_drops++;
                end
            end
        end
    endtask

    // Inputs are set at a falling edge; check, advance the model, then move to the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_outputs(tag);
        model_advance();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        #1;
        checks++;
        if (update_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL reset: got upd=%h empty=%b full=%b drop=%0d expected 0/1/0/0",
                     update_o, empty_o, full_o, drop_cnt_o);
        end
        mq.delete();
        m_drops = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle("reset_idle");
    endtask

    task automatic test_single();
        drive(1'b0, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 1'b0, 64'h0, 1'b0);
        cycle("single_push");
        idle();
        #1;
        checks++;
        if (update_o !== {1'b1, 64'h8000_0010, 1'b1}) begin
            failures++;
            $display("FAIL single_head: got %h expected %h", update_o, {1'b1, 64'h8000_0010, 1'b1});
        end
        cycle("single_out");
        cycle("single_empty");
    endtask

    task automatic test_pair();
        drive(1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 64'h104, 1'b0);
        cycle("pair_push");
        idle();
        for (int i = 0; i < 3; i++) cycle("pair_drain");
    endtask

    task automatic test_overflow();
        int unsigned d0;
        d0 = m_drops;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 64'h200 + 64'(16 * i), i[0], 1'b1, 64'h208 + 64'(16 * i), !i[0]);
            cycle("ovf_push");
        end
        idle();
        #1;
        checks++;
        if (full_o !== 1'b1 || drop_cnt_o !== 16'(d0 + 1)) begin
            failures++;
            $display("FAIL ovf_state: got full=%b drop=%0d expected full=1 drop=%0d",
                     full_o, drop_cnt_o, d0 + 1);
        end
        for (int i = 0; i < 5; i++) cycle("ovf_drain");
    endtask

    task automatic test_flush();
        logic [15:0] d0;
        drive(1'b0, 1'b0, 1'b1, 64'h300, 1'b0, 1'b1, 64'h304, 1'b1);
        cycle("flush_fill");
        drive(1'b0, 1'b0, 1'b1, 64'h308, 1'b1, 1'b1, 64'h30c, 1'b0);
        cycle("flush_fill");
        d0 = drop_cnt_o;
        drive(1'b1, 1'b0, 1'b1, 64'h310, 1'b1, 1'b1, 64'h314, 1'b1);
        cycle("flush_cycle");
        idle();
        #1;
        checks++;
        if (empty_o !== 1'b1 || update_o.valid !== 1'b0 || drop_cnt_o !== d0) begin
            failures++;
            $display("FAIL flush_after: got empty=%b valid=%b drop=%0d expected 1/0/%0d",
                     empty_o, update_o.valid, drop_cnt_o, d0);
        end
        cycle("flush_idle");
    endtask

    task automatic test_debug();
        int unsigned d0;
        d0 = m_drops;
        drive(1'b0, 1'b0, 1'b1, 64'h400, 1'b1, 1'b1, 64'h404, 1'b0);
        cycle("dbg_fill");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
            cycle("dbg_hold");
        end
        idle();
        for (int i = 0; i < 3; i++) cycle("dbg_drain");
        checks++;
        if (drop_cnt_o !== 16'(d0)) begin
            failures++;
            $display("FAIL dbg_drops: got %0d expected %0d", drop_cnt_o, d0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), {$urandom, $urandom}, 1'($urandom),
                  1'($urandom), {$urandom, $urandom}, 1'($urandom));
            cycle("random");
        end
        idle();
        for (int i = 0; i < 5; i++) cycle("random_drain");
    endtask

    task automatic test_saturate_reset();
        test_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, 64'h500 + 64'(16 * i), 1'b1, 1'b1, 64'h508 + 64'(16 * i), 1'b0);
            cycle("sat_push");
        end
        idle();
        #1;
        checks++;
        if (drop_s !== 2'b11 || drop_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL sat_count: got sat=%0d wide=%0d expected 3/5", drop_s, drop_cnt_o);
        end
        cycle("sat_drain");
        cycle("sat_drain");
        #3;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (update_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 || drop_cnt_o !== 16'd0
            || update_o_s !== '0 || drop_s !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: got upd=%h empty=%b full=%b drop=%0d sat=%0d expected zeros",
                     update_o, empty_o, full_o, drop_cnt_o, drop_s);
        end
        mq.delete();
        m_drops = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 64'h600, 1'b1, 1'b0, 64'h0, 1'b0);
        cycle("post_reset_push");
        idle();
        cycle("post_reset_out");
        cycle("post_reset_empty");
    endtask

    initial begin
        rst_ni  = 1'b0;
        m_drops = 0;
        idle();
        test_reset();
        test_single();
        test_pair();
        test_overflow();
        test_flush();
        test_debug();
        test_random();
        test_saturate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
